core_mem_port: RTL and testbench

Per-core initiator for one port of the 8-way time-division shared-memory controller. It turns a simple req/busy/ack handshake from a processing core into the controller's slot-based port, which has no handshake. The port keeps a replica of the controller's 3-bit slot counter, holds each request stable until its slot samples it, and parks the write enable low otherwise. For reads, it captures the returned word at the fixed slot offset and pulses `ack`. One instance sits between each core and its `addrN_/weN_/dataINN_/dataOUTN_` port group.

---
 rtl/core_mem_port.sv | 96 +++++++++
 tb/tb_core_mem_port.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_port.sv
// core_mem_port: slot-synchronous initiator for one port of the 8-way TDM memory controller.
// Define CORE_MEM_PORT_B2B_EN to complete straight to IDLE for zero-bubble back-to-back requests.
module core_mem_port #(
    parameter int CORE_ID = 0
) (
    input  logic        clk16,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [11:0] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic [15:0] rdata,
    output logic [11:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [2:0] SAMPLE_SLOT  = 3'(CORE_ID % 8);
    localparam logic [2:0] CAPTURE_SLOT = 3'((CORE_ID + 3) % 8);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RDWAIT,
        DONE
    } state_t;

    state_t     state;
    logic [2:0] slot;
    logic       finish;

    // mem_we doubles as the latched write flag until the sample edge
    always_comb begin
        finish = 1'b0;
        if (state == ARMED && slot == SAMPLE_SLOT && mem_we)
            finish = 1'b1;
        if (state == RDWAIT && slot == CAPTURE_SLOT)
            finish = 1'b1;
    end

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            slot      <= 3'd0;
            state     <= IDLE;
            busy      <= 1'b0;
            ack       <= 1'b0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            slot <= slot + 3'd1;
            ack  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        mem_addr  <= addr;
                        mem_we    <= we;
                        mem_wdata <= wdata;
                        busy      <= 1'b1;
                        state     <= ARMED;
                    end
                end
                ARMED: begin
                    if (slot == SAMPLE_SLOT) begin
                        mem_we <= 1'b0;
                        if (!mem_we)
                            state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    if (slot == CAPTURE_SLOT)
                        rdata <= mem_rdata;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (finish) begin
                ack <= 1'b1;
`ifdef CORE_MEM_PORT_B2B_EN
                busy  <= 1'b0;
                state <= IDLE;
`else
                state <= DONE;
`endif
            end
        end
    end

endmodule

// File: tb/tb_core_mem_port.sv
// tb_core_mem_port: directed and randomized checks of core_mem_port (CORE_ID=2)
// against a slot-level controller model and a transaction-level reference memory.
module tb_core_mem_port;

    localparam int CID = 2;
`ifdef CORE_MEM_PORT_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic        clk16;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
    logic        busy;
    logic        ack;
    logic [15:0] rdata;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int compared   = 0;
    int mismatched = 0;

    core_mem_port #(.CORE_ID(CID)) dut (
        .clk16     (clk16),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .ack       (ack),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk16 = 1'b0;
    always #5 clk16 = ~clk16;

    function automatic logic [15:0] init_word(input int a);
        if (a == 32)
            return 16'h1234;
        return 16'(a * 40503) ^ 16'h5A5A;
    endfunction

    // Controller model: edge count since reset is its slot counter
    int          cyc;
    int          wr_samples = 0;
    logic [11:0] pend_addr;
    logic [15:0] ctrl_mem [4096];

    always @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            cyc       <= 0;
            pend_addr <= '0;
            mem_rdata <= '0;
            for (int i = 0; i < 4096; i++)
                ctrl_mem[i] <= init_word(i);
        end else begin
            cyc <= cyc + 1;
            if (cyc % 8 == CID) begin
                pend_addr <= mem_addr;
                if (mem_we) begin
                    ctrl_mem[mem_addr] <= mem_wdata;
                    wr_samples <= wr_samples + 1;
                end
            end
            if (cyc % 8 == (CID + 2) % 8)
                mem_rdata <= ctrl_mem[pend_addr];
        end
    end

    logic [15:0] ref_mem [4096];

    task automatic init_ref();
        for (int i = 0; i < 4096; i++)
            ref_mem[i] = init_word(i);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sample_edge(input int k);
        return k + ((CID - (k % 8) + 7) % 8) + 1;
    endfunction

    task automatic wait_slot(input int s);
        for (int i = 0; i < 8 && (cyc % 8) != s; i++)
            @(negedge clk16);
    endtask

    // Drive one request, expect acceptance on edge exp_k; returns at the ack negedge
    task automatic run_txn(input logic t_we, input logic [11:0] t_addr,
                           input logic [15:0] t_wdata, input bit hold, input int exp_k);
        int k;
        int ks;
        int exp_ack;
        int n0;
        bit got;
        req   = 1'b1;
        we    = t_we;
        addr  = t_addr;
        wdata = t_wdata;
        n0    = wr_samples;
        k     = -1;
        for (int i = 0; i < 4 && k < 0; i++) begin
            int c;
            c = cyc;
            @(negedge clk16);
            if (busy)
                k = c;
        end
        chk("accept_edge", 32'(k), 32'(exp_k));
        if (k < 0) begin
            req = 1'b0;
            return;
        end
        chk("acc_busy", 32'(busy), 32'(1));
        chk("acc_we", 32'(mem_we), 32'(t_we));
        chk("acc_addr", 32'(mem_addr), 32'(t_addr));
        chk("acc_wdata", 32'(mem_wdata), 32'(t_wdata));
        if (!hold) begin
            req   = 1'b0;
            we    = 1'($urandom);
            addr  = 12'($urandom);
            wdata = 16'($urandom);
        end
        ks      = sample_edge(k);
        exp_ack = t_we ? ks + 1 : ks + 4;
        got     = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            if (cyc == ks) begin
                chk("held_we", 32'(mem_we), 32'(t_we));
                chk("held_addr", 32'(mem_addr), 32'(t_addr));
            end
            if (cyc == ks + 1)
                chk("parked_we", 32'(mem_we), 32'(0));
            if (ack)
                got = 1'b1;
            else
                @(negedge clk16);
        end
        chk("ack_seen", 32'(got), 32'(1));
        if (got) begin
            chk("ack_cyc", 32'(cyc), 32'(exp_ack));
            chk("ack_busy", 32'(busy), B2B ? 32'(0) : 32'(1));
            chk("samples", 32'(wr_samples - n0), 32'(t_we));
            if (t_we)
                ref_mem[t_addr] = t_wdata;
            else
                chk("rdata", 32'(rdata), 32'(ref_mem[t_addr]));
        end
    endtask

    task automatic finish_txn();
        req = 1'b0;
        @(negedge clk16);
        chk("ack_pulse", 32'(ack), 32'(0));
        chk("idle_busy", 32'(busy), 32'(0));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_ack"}, 32'(ack), 32'(0));
        chk({tag, "_rdata"}, 32'(rdata), 32'(0));
        chk({tag, "_maddr"}, 32'(mem_addr), 32'(0));
        chk({tag, "_mwe"}, 32'(mem_we), 32'(0));
        chk({tag, "_mwdata"}, 32'(mem_wdata), 32'(0));
    endtask

    initial begin
        int k;
        int ks;
        int acks;
        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;
        init_ref();
        repeat (3) @(negedge clk16);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk16);

        // Write accepted on the slot=5 edge
        wait_slot(5);
        run_txn(1'b1, 12'h010, 16'hBEEF, 1'b0, cyc);
        finish_txn();

        // Read accepted on the slot=1 edge
        wait_slot(1);
        run_txn(1'b0, 12'h020, 16'h0000, 1'b0, cyc);
        finish_txn();

        // Accepted on the port's own slot: waits a full rotation
        wait_slot(CID);
        run_txn(1'b0, 12'h010, 16'h0000, 1'b0, cyc);
        finish_txn();

        // req held high through a whole write
        run_txn(1'b1, 12'h033, 16'hA5C3, 1'b1, cyc);
        finish_txn();

        // Reset while waiting for read data
        wait_slot(6);
        k   = cyc;
        req = 1'b1;
        we  = 1'b0;
        addr = 12'h020;
        @(negedge clk16);
        req = 1'b0;
        ks  = sample_edge(k);
        for (int i = 0; i < 12 && cyc < ks + 2; i++)
            @(negedge clk16);
        chk("rdwait_busy", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        @(negedge clk16);
        @(negedge clk16);
        rst_n = 1'b1;
        init_ref();
        acks = 0;
        repeat (16) begin
            @(negedge clk16);
            if (ack)
                acks++;
        end
        chk("abort_no_ack", 32'(acks), 32'(0));

        // Randomized traffic over a small address window
        for (int n = 0; n < 14; n++) begin
            logic        r_we;
            logic [11:0] r_addr;
            logic [15:0] r_wdata;
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = 12'($urandom_range(0, 15));
            r_wdata = 16'($urandom);
            run_txn(r_we, r_addr, r_wdata, 1'($urandom_range(0, 1)), cyc);
            finish_txn();
            repeat ($urandom_range(0, 9)) @(negedge clk16);
        end

        // Back-to-back: second request already waiting in the ack cycle
        run_txn(1'b0, 12'h005, 16'h0000, 1'b1, cyc);
        run_txn(1'b1, 12'h006, 16'h7E57, 1'b0, B2B ? cyc : cyc + 1);
        finish_txn();
        run_txn(1'b0, 12'h006, 16'h0000, 1'b0, cyc);
        finish_txn();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
